decode_ctrl_pipe: RTL
=====================

Name: decode_ctrl_pipe

Overview:
Parametrised RV32I(+M) instruction decoder with a registered, handshaked ID->EX control-bundle buffer. It replaces the purely combinational decoder. It adds valid/ready flow control, synchronous flush, an optional 2-entry skid buffer, M-extension decode, and illegal-instruction detection with a saturating counter. It sits between the IF/ID register and the EX stage.

Parameters:
EN_MEXT, 1, 1 = decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 = these are illegal.
SKID, 1, 1 = 2-entry skid buffer; 0 = single pipeline register.
CNT_W, 8, width of illegal_cnt.

Ports:
CPU_CLK  in  1  clock, rising edge
CPU_RST_N  in  1  asynchronous active-low reset
in_valid  in  1  instr/pc_in valid
in_ready  out  1  buffer can accept
instr  in  32  instruction word
pc_in  in  32  PC of instr
flush  in  1  synchronous flush of all buffered entries
out_valid  out  1  head bundle valid
out_ready  in  1  EX accepts head bundle
out_pc  out  32  PC of head entry
jal / jalr / mem_to_reg / load_npc / alu_src1  out  1 each  control flags
reg_write  out  3  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU
mem_write  out  4  byte enables: SB 0001, SH 0011, SW 1111
reg_read  out  2  [1] rs1 used, [0] rs2 used
branch_type  out  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BLTU, 5 BGE, 6 BGEU
alu_ctrl  out  4  0 SLL, 1 SRL, 2 SRA, 3 ADD, 4 SUB, 5 XOR, 6 OR, 7 AND, 8 SLT, 9 SLTU, 10 LUI
alu_src2  out  2  0 rs2, 2 imm
imm_type  out  3  0 R, 1 I, 2 S, 3 B, 4 U, 5 J
is_muldiv  out  1  M-extension op
muldiv_op  out  3  funct3 of the M op; 0 when is_muldiv = 0
illegal  out  1  head entry is illegal
illegal_cnt  out  CNT_W  saturating count of accepted illegal instrs

Behaviour:
- Reset (CPU_RST_N low, async): buffer empty, out_valid = 0, all bundle outputs and out_pc = 0, illegal_cnt = 0. in_ready = 1 from the first edge after release.
- Decode is combinational on instr and is captured with pc_in on input fire (in_valid & in_ready). Outputs are driven only from registers. Latency is 1 cycle from fire to out_valid.
- Decode rules: RV32I semantics.
  - LUI: alu_ctrl 10, U-type. AUIPC: ADD, U-type, alu_src1 = 1.
  - JAL: J-type, jal = 1, alu_src1 = 1, reg_write 3.
  - JALR (funct3 = 000): jalr = 1, load_npc = 1, reg_read 10, I-type.
  - Loads: mem_to_reg = 1, reg_read 10. Stores: reg_read 11, S-type. Branches: reg_read 11, B-type.
  - Shift-immediates require funct7 = 0000000 (SRAI 0100000). R-ops require exact funct7.
  - M ops: opcode 0110011, funct7 0000001, reg_write 3, reg_read 11.
- Illegal: any unmatched opcode/funct3/funct7 combination, or an M op when EN_MEXT = 0. The entry is captured with illegal = 1 and all side-effect fields forced to 0: reg_write, mem_write, branch_type, jal, jalr, mem_to_reg, is_muldiv.
- illegal_cnt increments on input fire of an illegal instr and saturates at all-ones.
- SKID = 1: 2-entry FIFO; in_ready = (count < 2), registered. Output order is in order. Simultaneous in-fire and out-fire at count 1 or 2 leaves count unchanged.
- SKID = 0: single register; in_ready = !out_valid | out_ready.
- While out_valid = 1 and out_ready = 0, the head bundle and out_pc stay stable.
- flush: on the next edge count = 0 and out_valid = 0. Same-cycle input is dropped, and illegal_cnt does not count it. Bundle fields of an empty buffer are held at 0.

Test Plan:
- Reset then instr 0x00A00093 (ADDI x1,x0,10), valid 1, out_ready 1 -> next cycle out_valid 1, alu_ctrl 3, imm_type 1, reg_write 3, reg_read 10, alu_src2 2.
- SKID = 1, out_ready 0, push 3 instrs -> in_ready falls after 2 accepts. The 3rd is held upstream. Raise out_ready -> the 3 emerge in order, one per cycle.
- Push 0x02208033 (MUL) with EN_MEXT = 1 -> is_muldiv 1, muldiv_op 0. With EN_MEXT = 0 -> illegal 1, reg_write 0, illegal_cnt 1.
- Push 0xFFFFFFFF 300 times with CNT_W = 8 -> illegal_cnt saturates at 255.
- Buffer holding 2 entries, flush = 1 with in_valid = 1 -> next cycle out_valid 0, count 0, input dropped, in_ready 1.
- Push 0x00412023 (SW) then 0x0000C083 (LBU) -> mem_write 1111 / S-type; then reg_write 4, mem_to_reg 1. Assert CPU_RST_N low mid-stream -> outputs return to 0 immediately.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// RV32I(+M) instruction decoder feeding a registered, valid/ready ID->EX control buffer.
// Buffer is a 2-entry in-order skid FIFO (SKID=1) or a single pipeline register (SKID=0).
module decode_ctrl_pipe #(
    parameter int unsigned EN_MEXT = 1,
    parameter int unsigned SKID    = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      pc_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic             jal,
    output logic             jalr,
    output logic             mem_to_reg,
    output logic             load_npc,
    output logic             alu_src1,
    output logic [2:0]       reg_write,
    output logic [3:0]       mem_write,
    output logic [1:0]       reg_read,
    output logic [2:0]       branch_type,
    output logic [3:0]       alu_ctrl,
    output logic [1:0]       alu_src2,
    output logic [2:0]       imm_type,
    output logic             is_muldiv,
    output logic [2:0]       muldiv_op,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRL  = 4'd1;
    localparam logic [3:0] ALU_SRA  = 4'd2;
    localparam logic [3:0] ALU_ADD  = 4'd3;
    localparam logic [3:0] ALU_SUB  = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    localparam logic [2:0] IMM_R = 3'd0;
    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_J = 3'd5;

    localparam logic [1:0] SRC2_RS2 = 2'd0;
    localparam logic [1:0] SRC2_IMM = 2'd2;

    typedef struct packed {
        logic       jal;
        logic       jalr;
        logic       mem_to_reg;
        logic       load_npc;
        logic       alu_src1;
        logic [2:0] reg_write;
        logic [3:0] mem_write;
        logic [1:0] reg_read;
        logic [2:0] branch_type;
        logic [3:0] alu_ctrl;
        logic [1:0] alu_src2;
        logic [2:0] imm_type;
        logic       is_muldiv;
        logic [2:0] muldiv_op;
        logic       illegal;
    } bundle_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       bad;
    logic       unused_bits;
    bundle_t    dec;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    always_comb begin
        dec = '0;
        bad = 1'b0;
        case (opcode)
            OP_LUI: begin
                dec.alu_ctrl  = ALU_LUI;
                dec.imm_type  = IMM_U;
                dec.alu_src2  = SRC2_IMM;
                dec.reg_write = 3'd3;
            end
            OP_AUIPC: begin
                dec.alu_ctrl  = ALU_ADD;
                dec.imm_type  = IMM_U;
                dec.alu_src1  = 1'b1;
                dec.alu_src2  = SRC2_IMM;
                dec.reg_write = 3'd3;
            end
            OP_JAL: begin
                dec.jal       = 1'b1;
                dec.alu_src1  = 1'b1;
                dec.alu_ctrl  = ALU_ADD;
                dec.imm_type  = IMM_J;
                dec.alu_src2  = SRC2_IMM;
                dec.reg_write = 3'd3;
            end
            OP_JALR: begin
                dec.jalr      = 1'b1;
                dec.load_npc  = 1'b1;
                dec.reg_read  = 2'b10;
                dec.alu_ctrl  = ALU_ADD;
                dec.imm_type  = IMM_I;
                dec.alu_src2  = SRC2_IMM;
                dec.reg_write = 3'd3;
                bad           = (funct3 != 3'b000);
            end
            OP_LOAD: begin
                dec.mem_to_reg = 1'b1;
                dec.reg_read   = 2'b10;
                dec.alu_ctrl   = ALU_ADD;
                dec.imm_type   = IMM_I;
                dec.alu_src2   = SRC2_IMM;
                case (funct3)
                    3'b000:  dec.reg_write = 3'd1;
                    3'b001:  dec.reg_write = 3'd2;
                    3'b010:  dec.reg_write = 3'd3;
                    3'b100:  dec.reg_write = 3'd4;
                    3'b101:  dec.reg_write = 3'd5;
                    default: bad = 1'b1;
                endcase
            end
            OP_STORE: begin
                dec.reg_read = 2'b11;
                dec.alu_ctrl = ALU_ADD;
                dec.imm_type = IMM_S;
                dec.alu_src2 = SRC2_IMM;
                case (funct3)
                    3'b000:  dec.mem_write = 4'b0001;
                    3'b001:  dec.mem_write = 4'b0011;
                    3'b010:  dec.mem_write = 4'b1111;
                    default: bad = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                // Comparison runs through the ALU as a subtract of rs1 - rs2.
                dec.reg_read = 2'b11;
                dec.alu_ctrl = ALU_SUB;
                dec.imm_type = IMM_B;
                dec.alu_src2 = SRC2_RS2;
                case (funct3)
                    3'b000:  dec.branch_type = 3'd1;
                    3'b001:  dec.branch_type = 3'd2;
                    3'b100:  dec.branch_type = 3'd3;
                    3'b110:  dec.branch_type = 3'd4;
                    3'b101:  dec.branch_type = 3'd5;
                    3'b111:  dec.branch_type = 3'd6;
                    default: bad = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec.reg_read  = 2'b10;
                dec.imm_type  = IMM_I;
                dec.alu_src2  = SRC2_IMM;
                dec.reg_write = 3'd3;
                case (funct3)
                    3'b000: dec.alu_ctrl = ALU_ADD;
                    3'b010: dec.alu_ctrl = ALU_SLT;
                    3'b011: dec.alu_ctrl = ALU_SLTU;
                    3'b100: dec.alu_ctrl = ALU_XOR;
                    3'b110: dec.alu_ctrl = ALU_OR;
                    3'b111: dec.alu_ctrl = ALU_AND;
                    3'b001: begin
                        dec.alu_ctrl = ALU_SLL;
                        bad          = (funct7 != 7'b0000000);
                    end
                    default: begin
                        if (funct7 == 7'b0000000)      dec.alu_ctrl = ALU_SRL;
                        else if (funct7 == 7'b0100000) dec.alu_ctrl = ALU_SRA;
                        else                           bad = 1'b1;
                    end
                endcase
            end
            OP_REG: begin
                dec.reg_read  = 2'b11;
                dec.imm_type  = IMM_R;
                dec.alu_src2  = SRC2_RS2;
                dec.reg_write = 3'd3;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec.alu_ctrl = ALU_ADD;
                        3'b001:  dec.alu_ctrl = ALU_SLL;
                        3'b010:  dec.alu_ctrl = ALU_SLT;
                        3'b011:  dec.alu_ctrl = ALU_SLTU;
                        3'b100:  dec.alu_ctrl = ALU_XOR;
                        3'b101:  dec.alu_ctrl = ALU_SRL;
                        3'b110:  dec.alu_ctrl = ALU_OR;
                        default: dec.alu_ctrl = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    case (funct3)
                        3'b000:  dec.alu_ctrl = ALU_SUB;
                        3'b101:  dec.alu_ctrl = ALU_SRA;
                        default: bad = 1'b1;
                    endcase
                end else if (funct7 == 7'b0000001 && EN_MEXT != 0) begin
                    dec.is_muldiv = 1'b1;
                    dec.muldiv_op = funct3;
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
        // Illegal entries carry no side effects at all; only the flag survives.
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    bundle_t          ent0, ent1;
    logic [31:0]      pc0, pc1;
    logic [1:0]       cnt;
    logic             alive;
    logic [CNT_W-1:0] ill_cnt;
    logic             push, pop;

    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & in_ready & ~flush;

    always_comb begin
        if (SKID != 0) in_ready = alive && (cnt != 2'd2);
        else           in_ready = alive && ((cnt == 2'd0) || out_ready);
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            alive   <= 1'b0;
            cnt     <= 2'd0;
            ent0    <= '0;
            ent1    <= '0;
            pc0     <= '0;
            pc1     <= '0;
            ill_cnt <= '0;
        end else begin
            alive <= 1'b1;
            if (flush) begin
                cnt  <= 2'd0;
                ent0 <= '0;
                ent1 <= '0;
                pc0  <= '0;
                pc1  <= '0;
            end else begin
                // Head slot is zeroed whenever it empties so idle outputs read 0.
                case (cnt)
                    2'd0: begin
                        if (push) begin
                            ent0 <= dec;
                            pc0  <= pc_in;
                            cnt  <= 2'd1;
                        end
                    end
                    2'd1: begin
                        if (push && pop) begin
                            ent0 <= dec;
                            pc0  <= pc_in;
                        end else if (pop) begin
                            ent0 <= '0;
                            pc0  <= '0;
                            cnt  <= 2'd0;
                        end else if (push) begin
                            ent1 <= dec;
                            pc1  <= pc_in;
                            cnt  <= 2'd2;
                        end
                    end
                    default: begin
                        if (pop) begin
                            ent0 <= ent1;
                            pc0  <= pc1;
                            if (push) begin
                                ent1 <= dec;
                                pc1  <= pc_in;
                            end else begin
                                ent1 <= '0;
                                pc1  <= '0;
                                cnt  <= 2'd1;
                            end
                        end
                    end
                endcase
            end
            if (push && dec.illegal && (ill_cnt != '1))
                ill_cnt <= ill_cnt + 1'b1;
        end
    end

    assign out_pc      = pc0;
    assign jal         = ent0.jal;
    assign jalr        = ent0.jalr;
    assign mem_to_reg  = ent0.mem_to_reg;
    assign load_npc    = ent0.load_npc;
    assign alu_src1    = ent0.alu_src1;
    assign reg_write   = ent0.reg_write;
    assign mem_write   = ent0.mem_write;
    assign reg_read    = ent0.reg_read;
    assign branch_type = ent0.branch_type;
    assign alu_ctrl    = ent0.alu_ctrl;
    assign alu_src2    = ent0.alu_src2;
    assign imm_type    = ent0.imm_type;
    assign is_muldiv   = ent0.is_muldiv;
    assign muldiv_op   = ent0.muldiv_op;
    assign illegal     = ent0.illegal;
    assign illegal_cnt = ill_cnt;

endmodule
